// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

  // 2-bit saturating direction counter; MSB is the taken prediction.
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT_ALLOC = 2'b10;
  localparam ctr_t CTR_RESET      = 2'b01;

  // Move the counter one step toward the resolved direction, saturating at both ends.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t result;
    result = ctr;
    if (taken) begin
      if (ctr != 2'b11) result = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) result = ctr - 2'b01;
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_assoc_core_if.sv
// Fetch-side lookup, execute-side update and flush bundle for btb_assoc_core.
interface btb_assoc_core_if #(
  parameter int PC_W     = 32,
  parameter int TARGET_W = 32,
  parameter int NUM_WAYS = 2
);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                lk_valid_i;
  logic [PC_W-1:0]     lk_pc_i;
  logic                lk_valid_o;
  logic                lk_hit_o;
  logic [WAY_W-1:0]    lk_way_o;
  logic [TARGET_W-1:0] lk_target_o;
  logic                lk_taken_o;
  logic                upd_valid_i;
  logic [PC_W-1:0]     upd_pc_i;
  logic [TARGET_W-1:0] upd_target_i;
  logic                upd_taken_i;
  logic                flush_i;

  modport master (
    output lk_valid_i, lk_pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, flush_i,
    input  lk_valid_o, lk_hit_o, lk_way_o, lk_target_o, lk_taken_o
  );

  modport slave (
    input  lk_valid_i, lk_pc_i, upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i, flush_i,
    output lk_valid_o, lk_hit_o, lk_way_o, lk_target_o, lk_taken_o
  );

endinterface

// File: rtl/btb_victim_sel.sv
// Picks the way to allocate into: first free way, otherwise the round-robin pointer.
module btb_victim_sel
  import btb_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [WAY_W-1:0]    ptr_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic                from_ptr_o
);

  // Scan from the top down so the lowest-numbered invalid way is the last one written.
  always_comb begin
    victim_o   = ptr_i;
    from_ptr_o = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o   = WAY_W'(w);
        from_ptr_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/btb_assoc_core.sv
// N-way set-associative branch target buffer: one-cycle registered lookup,
// single training port with allocate-on-taken-miss and round-robin replacement.
module btb_assoc_core
  import btb_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2,
  parameter int PC_W     = 32,
  parameter int TARGET_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  btb_assoc_core_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [TARGET_W-1:0] target;
    ctr_t                ctr;
  } entry_t;

  // Storage split so that only valid bits, counters and pointers carry a reset.
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  ctr_t                ctr_q    [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
  logic [TARGET_W-1:0] target_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    ptr_q    [NUM_SETS];

  logic                lkValid_q, lkHit_q, lkTaken_q;
  logic [WAY_W-1:0]    lkWay_q;
  logic [TARGET_W-1:0] lkTarget_q;
  logic                lkHit_d, lkTaken_d;
  logic [WAY_W-1:0]    lkWay_d;
  logic [TARGET_W-1:0] lkTarget_d;

  logic [IDX_W-1:0]    lkIdx, updIdx;
  logic [TAG_W-1:0]    lkTag, updTag;
  logic                updHit;
  logic [WAY_W-1:0]    updHitWay, victimWay, wrWay, ptrNext;
  logic                victimFromPtr;
  entry_t              allocEntry;
  logic                unusedPcBits;

  assign lkIdx  = bus.lk_pc_i[IDX_W+1:2];
  assign lkTag  = bus.lk_pc_i[PC_W-1:IDX_W+2];
  assign updIdx = bus.upd_pc_i[IDX_W+1:2];
  assign updTag = bus.upd_pc_i[PC_W-1:IDX_W+2];
  assign unusedPcBits = ^{bus.lk_pc_i[1:0], bus.upd_pc_i[1:0]};

  // Lookup tag compare; descending scan makes the lowest hitting way win on a multi-hit.
  always_comb begin
    lkHit_d    = 1'b0;
    lkWay_d    = '0;
    lkTarget_d = '0;
    lkTaken_d  = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (bus.lk_valid_i && valid_q[lkIdx][w] && (tag_q[lkIdx][w] == lkTag)) begin
        lkHit_d    = 1'b1;
        lkWay_d    = WAY_W'(w);
        lkTarget_d = target_q[lkIdx][w];
        lkTaken_d  = ctr_q[lkIdx][w][1];
      end
    end
  end

  // Update-side tag compare, same lowest-way priority as the lookup.
  always_comb begin
    updHit    = 1'b0;
    updHitWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[updIdx][w] && (tag_q[updIdx][w] == updTag)) begin
        updHit    = 1'b1;
        updHitWay = WAY_W'(w);
      end
    end
  end

  btb_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) uVictimSel (
    .valid_i    (valid_q[updIdx]),
    .ptr_i      (ptr_q[updIdx]),
    .victim_o   (victimWay),
    .from_ptr_o (victimFromPtr)
  );

  assign wrWay   = updHit ? updHitWay : victimWay;
  assign ptrNext = (ptr_q[updIdx] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q[updIdx] + WAY_W'(1);
  assign allocEntry = '{valid: 1'b1, tag: updTag, target: bus.upd_target_i, ctr: CTR_INIT_ALLOC};

  // Valid bits, counters and victim pointers; flush wins over a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < NUM_WAYS; w++) ctr_q[s][w] <= CTR_RESET;
      end
    end else if (bus.flush_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (bus.upd_valid_i) begin
      if (updHit) begin
        ctr_q[updIdx][wrWay] <= sat_update(ctr_q[updIdx][wrWay], bus.upd_taken_i);
      end else if (bus.upd_taken_i) begin
        valid_q[updIdx][wrWay] <= allocEntry.valid;
        ctr_q[updIdx][wrWay]   <= allocEntry.ctr;
        if (victimFromPtr) ptr_q[updIdx] <= ptrNext;
      end
    end
  end

  // Tag and target arrays need no reset; a stale entry is never visible while invalid.
  always_ff @(posedge clk) begin
    if (!bus.flush_i && bus.upd_valid_i && bus.upd_taken_i) begin
      target_q[updIdx][wrWay] <= allocEntry.target;
      if (!updHit) tag_q[updIdx][wrWay] <= allocEntry.tag;
    end
  end

  // Registered lookup result, read from pre-update contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lkValid_q  <= 1'b0;
      lkHit_q    <= 1'b0;
      lkWay_q    <= '0;
      lkTarget_q <= '0;
      lkTaken_q  <= 1'b0;
    end else begin
      lkValid_q  <= bus.lk_valid_i;
      lkHit_q    <= lkHit_d;
      lkWay_q    <= lkWay_d;
      lkTarget_q <= lkTarget_d;
      lkTaken_q  <= lkTaken_d;
    end
  end

  assign bus.lk_valid_o  = lkValid_q;
  assign bus.lk_hit_o    = lkHit_q;
  assign bus.lk_way_o    = lkWay_q;
  assign bus.lk_target_o = lkTarget_q;
  assign bus.lk_taken_o  = lkTaken_q;

endmodule

// File: tb/tb_btb_assoc_core.sv
// Scoreboard bench for btb_assoc_core: a default 2-way/8-set instance and a 4-way/16-set instance.
module tb_btb_assoc_core;

  logic clk;
  logic rst_n;
  int   totalCount;
  int   badCount;

  typedef struct packed {
    logic        valid;
    logic        hit;
    logic [1:0]  way;
    logic [31:0] target;
    logic        taken;
  } exp_t;

  exp_t expA[$];
  exp_t expB[$];

  btb_assoc_core_if #(.PC_W(32), .TARGET_W(32), .NUM_WAYS(2)) busA ();
  btb_assoc_core_if #(.PC_W(32), .TARGET_W(32), .NUM_WAYS(4)) busB ();

  btb_assoc_core #(.NUM_SETS(8), .NUM_WAYS(2), .PC_W(32), .TARGET_W(32)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  btb_assoc_core #(.NUM_SETS(16), .NUM_WAYS(4), .PC_W(32), .TARGET_W(32)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus on the chosen instance; the other instance idles.
  task automatic applyStimulus(input int dut, input logic lkV, input logic [31:0] lkPc,
                               input logic updV, input logic [31:0] updPc,
                               input logic [31:0] updTgt, input logic updT, input logic fl,
                               input logic eHit, input logic [1:0] eWay,
                               input logic [31:0] eTgt, input logic eTaken);
    exp_t e;
    @(negedge clk);
    e = '{valid: lkV, hit: eHit, way: eWay, target: eTgt, taken: eTaken};
    if (dut == 0) begin
      busA.lk_valid_i = lkV;   busA.lk_pc_i = lkPc;
      busA.upd_valid_i = updV; busA.upd_pc_i = updPc;
      busA.upd_target_i = updTgt; busA.upd_taken_i = updT; busA.flush_i = fl;
      busB.lk_valid_i = 1'b0;  busB.upd_valid_i = 1'b0; busB.flush_i = 1'b0;
      expA.push_back(e);
    end else begin
      busB.lk_valid_i = lkV;   busB.lk_pc_i = lkPc;
      busB.upd_valid_i = updV; busB.upd_pc_i = updPc;
      busB.upd_target_i = updTgt; busB.upd_taken_i = updT; busB.flush_i = fl;
      busA.lk_valid_i = 1'b0;  busA.upd_valid_i = 1'b0; busA.flush_i = 1'b0;
      expB.push_back(e);
    end
  endtask

  task automatic lookup(input int dut, input logic [31:0] pc, input logic eHit,
                        input logic [1:0] eWay, input logic [31:0] eTgt, input logic eTaken);
    applyStimulus(dut, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, eHit, eWay, eTgt, eTaken);
  endtask

  // Lookup request held low with a PC that would hit: the result must be all zero.
  task automatic update(input int dut, input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    applyStimulus(dut, 1'b0, pc, 1'b1, pc, tgt, taken, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic flush(input int dut);
    applyStimulus(dut, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b0);
  endtask

  // Pop one expectation per lookup cycle, sampled just after the registering edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && expA.size() > 0) begin
      e = expA.pop_front();
      checkOutput("A.valid",  {31'd0, busA.lk_valid_o}, {31'd0, e.valid});
      checkOutput("A.hit",    {31'd0, busA.lk_hit_o},   {31'd0, e.hit});
      checkOutput("A.way",    {31'd0, busA.lk_way_o},   {30'd0, e.way});
      checkOutput("A.target", busA.lk_target_o,         e.target);
      checkOutput("A.taken",  {31'd0, busA.lk_taken_o}, {31'd0, e.taken});
    end
    if (rst_n && expB.size() > 0) begin
      e = expB.pop_front();
      checkOutput("B.valid",  {31'd0, busB.lk_valid_o}, {31'd0, e.valid});
      checkOutput("B.hit",    {31'd0, busB.lk_hit_o},   {31'd0, e.hit});
      checkOutput("B.way",    {30'd0, busB.lk_way_o},   {30'd0, e.way});
      checkOutput("B.target", busB.lk_target_o,         e.target);
      checkOutput("B.taken",  {31'd0, busB.lk_taken_o}, {31'd0, e.taken});
    end
  end

  initial begin
    totalCount = 0;
    badCount   = 0;
    rst_n      = 1'b0;
    busA.lk_valid_i = 1'b1; busA.lk_pc_i = 32'h1000; busA.upd_valid_i = 1'b0;
    busA.upd_pc_i = '0; busA.upd_target_i = '0; busA.upd_taken_i = 1'b0; busA.flush_i = 1'b0;
    busB.lk_valid_i = 1'b1; busB.lk_pc_i = 32'h1000; busB.upd_valid_i = 1'b0;
    busB.upd_pc_i = '0; busB.upd_target_i = '0; busB.upd_taken_i = 1'b0; busB.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.A.valid",  {31'd0, busA.lk_valid_o}, 32'd0);
    checkOutput("rst.A.hit",    {31'd0, busA.lk_hit_o},   32'd0);
    checkOutput("rst.A.target", busA.lk_target_o,         32'd0);
    checkOutput("rst.B.valid",  {31'd0, busB.lk_valid_o}, 32'd0);
    checkOutput("rst.B.taken",  {31'd0, busB.lk_taken_o}, 32'd0);
    busA.lk_valid_i = 1'b0;
    busB.lk_valid_i = 1'b0;
    rst_n = 1'b1;

    $display("[TB] cold lookup and counter training");
    lookup(0, 32'h1000, 1'b0, 2'd0, 32'h0, 1'b0);
    update(0, 32'h1000, 32'h2000, 1'b1);
    lookup(0, 32'h1000, 1'b1, 2'd0, 32'h2000, 1'b1);
    update(0, 32'h1000, 32'h2000, 1'b0);
    update(0, 32'h1000, 32'h2000, 1'b0);
    lookup(0, 32'h1000, 1'b1, 2'd0, 32'h2000, 1'b0);
    update(0, 32'h1000, 32'h2000, 1'b0);
    update(0, 32'h1000, 32'h2400, 1'b1);
    lookup(0, 32'h1000, 1'b1, 2'd0, 32'h2400, 1'b0);
    update(0, 32'h1000, 32'h2400, 1'b1);
    update(0, 32'h1000, 32'h2400, 1'b1);
    update(0, 32'h1000, 32'h2400, 1'b1);
    update(0, 32'h1000, 32'h2400, 1'b0);
    update(0, 32'h1000, 32'h2400, 1'b0);
    lookup(0, 32'h1000, 1'b1, 2'd0, 32'h2400, 1'b0);

    $display("[TB] 2-way replacement");
    flush(0);
    lookup(0, 32'h1000, 1'b0, 2'd0, 32'h0, 1'b0);
    update(0, 32'h1000, 32'hA000, 1'b1);
    update(0, 32'h1020, 32'hA020, 1'b1);
    update(0, 32'h1040, 32'hA040, 1'b1);
    lookup(0, 32'h1000, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(0, 32'h1040, 1'b1, 2'd0, 32'hA040, 1'b1);
    lookup(0, 32'h1020, 1'b1, 2'd1, 32'hA020, 1'b1);
    lookup(0, 32'h1044, 1'b0, 2'd0, 32'h0, 1'b0);
    update(0, 32'h1060, 32'hA060, 1'b1);
    lookup(0, 32'h1020, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(0, 32'h1060, 1'b1, 2'd1, 32'hA060, 1'b1);
    update(0, 32'h1080, 32'hA080, 1'b1);
    lookup(0, 32'h1080, 1'b1, 2'd0, 32'hA080, 1'b1);
    lookup(0, 32'h1040, 1'b0, 2'd0, 32'h0, 1'b0);

    $display("[TB] read-before-write");
    applyStimulus(0, 1'b1, 32'h3000, 1'b1, 32'h3000, 32'hB000, 1'b1, 1'b0,
                  1'b0, 2'd0, 32'h0, 1'b0);
    lookup(0, 32'h3000, 1'b1, 2'd1, 32'hB000, 1'b1);
    applyStimulus(0, 1'b1, 32'h3000, 1'b1, 32'h3000, 32'hB000, 1'b0, 1'b0,
                  1'b1, 2'd1, 32'hB000, 1'b1);
    lookup(0, 32'h3000, 1'b1, 2'd1, 32'hB000, 1'b0);

    $display("[TB] flush against update");
    applyStimulus(0, 1'b1, 32'h3000, 1'b1, 32'h3000, 32'hC000, 1'b1, 1'b1,
                  1'b1, 2'd1, 32'hB000, 1'b0);
    lookup(0, 32'h3000, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(0, 32'h1080, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(0, 32'h3000, 1'b0, 2'd0, 32'h0, 1'b0);

    $display("[TB] 4-way, 16-set replacement");
    update(1, 32'h1000, 32'hD000, 1'b1);
    update(1, 32'h1040, 32'hD040, 1'b1);
    update(1, 32'h1080, 32'hD080, 1'b1);
    update(1, 32'h10C0, 32'hD0C0, 1'b1);
    lookup(1, 32'h10C0, 1'b1, 2'd3, 32'hD0C0, 1'b1);
    update(1, 32'h1100, 32'hD100, 1'b1);
    lookup(1, 32'h1000, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(1, 32'h1100, 1'b1, 2'd0, 32'hD100, 1'b1);
    update(1, 32'h1140, 32'hD140, 1'b0);
    lookup(1, 32'h1140, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(1, 32'h1040, 1'b1, 2'd1, 32'hD040, 1'b1);
    update(1, 32'h1180, 32'hD180, 1'b1);
    lookup(1, 32'h1040, 1'b0, 2'd0, 32'h0, 1'b0);
    lookup(1, 32'h1180, 1'b1, 2'd1, 32'hD180, 1'b1);
    lookup(1, 32'h1080, 1'b1, 2'd2, 32'hD080, 1'b1);

    @(negedge clk);
    busA.lk_valid_i = 1'b0; busA.upd_valid_i = 1'b0; busA.flush_i = 1'b0;
    busB.lk_valid_i = 1'b0; busB.upd_valid_i = 1'b0; busB.flush_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("sb.drained", expA.size() + expB.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/btb_assoc_core.md
Name: btb_assoc_core

Overview:
- Parametrised N-way set-associative Branch Target Buffer with integrated storage, lookup pipeline, update/allocate path and per-set replacement.
- Sits in the fetch stage: fetch PC in, registered prediction (hit, target, taken) out one cycle later.
- Execute-stage branch resolution trains it through a single update port.
- Generalises the fixed 2-way, 8-set, combinational read slice:
  - arbitrary ways and sets;
  - 2-bit saturating counters;
  - replacement and flush.

Parameters:
- NUM_SETS, 8, number of sets; power of two, at least 2; IDX_W = log2(NUM_SETS).
- NUM_WAYS, 2, associativity; at least 1.
- PC_W, 32, PC width; PC bits [1:0] ignored (word-aligned).
- TARGET_W, 32, stored target width.
- TAG_W, PC_W-IDX_W-2, derived, not overridable; 27 at defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lk_valid_i  in  1  lookup request this cycle.
- lk_pc_i  in  PC_W  fetch PC.
- lk_valid_o  out  1  registered copy of lk_valid_i.
- lk_hit_o  out  1  lookup hit (valid entry with matching tag).
- lk_way_o  out  max(1,log2(NUM_WAYS))  way that hit; 0 on miss.
- lk_target_o  out  TARGET_W  target of the hitting way; 0 on miss.
- lk_taken_o  out  1  counter MSB of the hitting way; 0 on miss.
- upd_valid_i  in  1  resolved-branch update.
- upd_pc_i  in  PC_W  PC of the resolved branch.
- upd_target_i  in  TARGET_W  resolved target.
- upd_taken_i  in  1  resolved direction.
- flush_i  in  1  synchronous invalidate of all entries.

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits 0, all counters 2'b01, all victim pointers 0;
  - all lk_*_o outputs 0.
  - Tags and targets need no reset.
- Address split:
  - index = pc[IDX_W+1:2];
  - tag = pc[PC_W-1:IDX_W+2].
- Lookup (latency 1):
  - Read the set at the index in cycle N; results are registered and visible in cycle N+1.
  - When lk_valid_i=0, the next cycle drives lk_valid_o=0 and hit/target/taken/way = 0.
- Multi-hit (illegal, defensive): the lowest-numbered hitting way wins.
- Update, applied at the clock edge:
  - Hit in way w:
    - counter saturates: increment if taken, capped at 11; decrement if not taken, floored at 00;
    - target overwritten only when upd_taken_i=1;
    - victim pointer unchanged.
  - Miss with upd_taken_i=1, allocate:
    - victim = lowest-numbered invalid way, else the set's victim pointer;
    - write valid=1, tag, target, counter 2'b10;
    - if the victim came from the pointer, the pointer advances modulo NUM_WAYS (wraps NUM_WAYS-1 -> 0).
  - Miss with upd_taken_i=0: no state change.
- Same-cycle lookup and update to the same set/way: the lookup returns pre-update contents (read-before-write). No bypass.
- flush_i:
  - clears all valid bits and resets victim pointers at the edge;
  - has priority over a simultaneous update, which is dropped;
  - does not cancel the lookup result registered on the same edge, which reflects pre-flush contents.
- No back-pressure: one lookup and one update are accepted every cycle.
- Reset asserted mid-operation: all state clears immediately (async); any in-flight lookup result is lost.

Decomposition:
- Package btb_pkg:
  - ctr_t (2-bit counter) and constants CTR_INIT_ALLOC=2'b10, CTR_RESET=2'b01;
  - function sat_update(ctr_t, taken);
  - entry struct {valid, tag, target, ctr} parametrised through the module.
- One sub-module, btb_victim_sel (combinational):
  - inputs: per-way valid vector, victim pointer;
  - outputs: victim way and a from_ptr flag.
- Tag compare and priority encoding stay inline.

Test Plan:
- Reset, then lookup pc=0x0000_1000 -> next cycle: lk_valid_o=1, lk_hit_o=0, lk_target_o=0, lk_taken_o=0.
- Update pc=0x1000 taken target=0x2000, then lookup 0x1000 -> hit=1, target=0x2000, taken=1 (ctr=10). Two not-taken updates -> taken=0 (ctr=00). A third not-taken update -> ctr stays 00.
- Defaults; allocate taken branches 0x1000, 0x1020, 0x1040, all in set 0 -> way0, way1, then way0 evicted (pointer wraps). Lookup 0x1000 -> miss; lookup 0x1040 -> hit, lk_way_o=0.
- Same cycle: lookup and allocating update for 0x3000 -> that lookup misses; a lookup the following cycle hits.
- Hit entry; flush_i=1 together with update of the same pc -> the next lookup misses; the dropped update does not reappear.
- NUM_SETS=16, NUM_WAYS=4: fill one set with 5 taken branches -> the 5th replaces way0. Not-taken miss to a full set -> no entry changes and the pointer is unchanged.
